// File: rtl/sprite_line_fetcher_if.sv
// Sprite ROM read bus.
//   rom_addr : read address from the fetcher (master drives)
//   rom_data : palette index returned by the ROM one cycle after rom_addr
// master = fetcher (read initiator), slave = ROM.
interface sprite_line_fetcher_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher: fetches one sprite row per scanline during horizontal
// blanking into a double-buffered line buffer, then serves palette index and
// opaque flag for each draw_x of the following active line.
//
// Ports:
//   Clk, Reset_n      pixel clock, async active-low reset
//   line_start        1-cycle pulse at start of hblank (swaps buffers, starts fetch)
//   next_y/spr_x/spr_y  scanline to fetch for and sprite origin, sampled on line_start
//   rom               ROM read bus (master): registered rom_addr, 1-cycle rom_data
//   draw_x            current pixel column
//   pix_index/pix_valid  registered palette index / opaque flag for draw_x
//   busy, fetch_done  fetch in progress / 1-cycle completion pulse (hit or miss)
//
// Optional feature macro: SPRITE_MIRROR_EN adds input flip_x (sampled on
// line_start); when set the row is stored horizontally mirrored.
module sprite_line_fetcher #(
  parameter int SPR_W       = 73,
  parameter int SPR_H       = 82,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 4,
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int TRANSPARENT = 0
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                line_start,
  input  logic [Y_W-1:0]      next_y,
  input  logic [X_W-1:0]      spr_x,
  input  logic [Y_W-1:0]      spr_y,
`ifdef SPRITE_MIRROR_EN
  input  logic                flip_x,
`endif
  sprite_line_fetcher_if.master rom,
  input  logic [X_W-1:0]      draw_x,
  output logic [DATA_W-1:0]   pix_index,
  output logic                pix_valid,
  output logic                busy,
  output logic                fetch_done
);
  localparam int CW = $clog2(SPR_W);
  localparam logic [CW-1:0] LAST = CW'(SPR_W - 1);

  typedef enum logic [1:0] {IDLE, CHECK, FETCH, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [Y_W-1:0]      next_y_q, next_y_d, spr_y_q, spr_y_d;
  logic [X_W-1:0]      fetch_x_q, fetch_x_d, disp_x_q, disp_x_d;
  logic                fill_valid_q, fill_valid_d, disp_valid_q, disp_valid_d;
  logic                disp_sel_q, disp_sel_d;
  logic [DATA_W-1:0]   pix_index_q, pix_index_d;
  logic                pix_valid_q, pix_valid_d;
  logic                mirror;

  logic [DATA_W-1:0]   buf_q [2][SPR_W];
  logic                wr_en;
  logic [CW-1:0]       wr_idx;

`ifdef SPRITE_MIRROR_EN
  logic flip_q, flip_d;
  assign mirror = flip_q;
`else
  assign mirror = 1'b0;
`endif

  function automatic logic [ADDR_W-1:0] col_off(input logic [CW-1:0] c, input logic flip);
    return flip ? ADDR_W'(SPR_W - 1) - ADDR_W'(c) : ADDR_W'(c);
  endfunction

  // Row within the sprite; the extra MSB makes above-the-sprite lines negative.
  logic [Y_W:0]       row;
  logic               hit;
  logic [ADDR_W-1:0]  row_base;
  logic [CW-1:0]      col_nxt;
  assign row      = {1'b0, next_y_q} - {1'b0, spr_y_q};
  assign hit      = !row[Y_W] && (row < (Y_W+1)'(SPR_H));
  assign row_base = ADDR_W'(row[Y_W-1:0]) * ADDR_W'(SPR_W);
  assign col_nxt  = col_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    base_d       = base_q;
    rom_addr_d   = rom_addr_q;
    next_y_d     = next_y_q;
    spr_y_d      = spr_y_q;
    fetch_x_d    = fetch_x_q;
    disp_x_d     = disp_x_q;
    fill_valid_d = fill_valid_q;
    disp_valid_d = disp_valid_q;
    disp_sel_d   = disp_sel_q;
`ifdef SPRITE_MIRROR_EN
    flip_d       = flip_q;
`endif
    wr_en        = 1'b0;
    wr_idx       = '0;
    fetch_done   = 1'b0;
    busy         = (state_q != IDLE);

    case (state_q)
      CHECK: begin
        if (hit) begin
          base_d     = row_base;
          col_d      = '0;
          rom_addr_d = row_base + col_off('0, mirror);
          state_d    = FETCH;
        end else begin
          fetch_done = 1'b1;
          state_d    = IDLE;
        end
      end
      FETCH: begin
        // rom_data now holds the word addressed for the previous column.
        if (col_q != '0) begin
          wr_en  = 1'b1;
          wr_idx = col_q - 1'b1;
        end
        if (col_q == LAST) begin
          state_d = DRAIN;
        end else begin
          col_d      = col_nxt;
          rom_addr_d = base_q + col_off(col_nxt, mirror);
        end
      end
      DRAIN: begin
        wr_en        = 1'b1;
        wr_idx       = LAST;
        fill_valid_d = 1'b1;
        fetch_done   = 1'b1;
        state_d      = IDLE;
      end
      default: ;
    endcase

    // line_start wins over any in-flight fetch: an aborted buffer swaps to
    // display with its valid flag still clear.
    if (line_start) begin
      next_y_d     = next_y;
      spr_y_d      = spr_y;
      fetch_x_d    = spr_x;
      disp_x_d     = fetch_x_q;
      disp_valid_d = fill_valid_q;
      disp_sel_d   = ~disp_sel_q;
      fill_valid_d = 1'b0;
`ifdef SPRITE_MIRROR_EN
      flip_d       = flip_x;
`endif
      state_d      = CHECK;
    end
  end

  // Display lookup; dx is signed so left-clipped sprites fall out of range.
  logic [X_W:0]       dx;
  logic               in_rng;
  logic [CW-1:0]      rd_idx;
  logic [DATA_W-1:0]  px;
  assign dx     = {1'b0, draw_x} - {1'b0, disp_x_q};
  assign in_rng = !dx[X_W] && (dx < (X_W+1)'(SPR_W));
  assign rd_idx = in_rng ? dx[CW-1:0] : '0;
  assign px     = buf_q[disp_sel_q][rd_idx];

  always_comb begin
    pix_valid_d = disp_valid_q && in_rng && (px != DATA_W'(TRANSPARENT));
    pix_index_d = in_rng ? px : '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      base_q       <= '0;
      rom_addr_q   <= '0;
      next_y_q     <= '0;
      spr_y_q      <= '0;
      fetch_x_q    <= '0;
      disp_x_q     <= '0;
      fill_valid_q <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_sel_q   <= 1'b0;
      pix_index_q  <= '0;
      pix_valid_q  <= 1'b0;
`ifdef SPRITE_MIRROR_EN
      flip_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      base_q       <= base_d;
      rom_addr_q   <= rom_addr_d;
      next_y_q     <= next_y_d;
      spr_y_q      <= spr_y_d;
      fetch_x_q    <= fetch_x_d;
      disp_x_q     <= disp_x_d;
      fill_valid_q <= fill_valid_d;
      disp_valid_q <= disp_valid_d;
      disp_sel_q   <= disp_sel_d;
      pix_index_q  <= pix_index_d;
      pix_valid_q  <= pix_valid_d;
`ifdef SPRITE_MIRROR_EN
      flip_q       <= flip_d;
`endif
    end
  end

  // Line buffer storage needs no reset; validity is tracked by the flags.
  always_ff @(posedge Clk) begin
    if (wr_en) buf_q[~disp_sel_q][wr_idx] <= rom.rom_data;
  end

  assign rom.rom_addr = rom_addr_q;
  assign pix_index    = pix_index_q;
  assign pix_valid    = pix_valid_q;
endmodule

// File: tb/tb_sprite_line_fetcher.sv
module tb_sprite_line_fetcher;
  localparam int SPR_W  = 73;
  localparam int SPR_H  = 82;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 4;
  localparam int X_W    = 10;
  localparam int Y_W    = 10;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              line_start;
  logic [Y_W-1:0]    next_y, spr_y;
  logic [X_W-1:0]    spr_x, draw_x;
  logic              flip_x;
  logic [DATA_W-1:0] pix_index;
  logic              pix_valid, busy, fetch_done;

  int n_chk = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  sprite_line_fetcher_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rom_bus();

  sprite_line_fetcher #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .X_W(X_W), .Y_W(Y_W), .TRANSPARENT(0)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .line_start(line_start),
    .next_y(next_y), .spr_x(spr_x), .spr_y(spr_y),
`ifdef SPRITE_MIRROR_EN
    .flip_x(flip_x),
`endif
    .rom(rom_bus.master), .draw_x(draw_x),
    .pix_index(pix_index), .pix_valid(pix_valid),
    .busy(busy), .fetch_done(fetch_done)
  );

  // Synchronous ROM: data for the address presented in one cycle appears the next.
  always @(posedge Clk) rom_bus.rom_data <= mem[rom_bus.rom_addr];

  always #5 Clk = ~Clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Pulse line_start for one cycle (cycle t); returns in cycle t+1.
  task automatic start_line(input int ny, input int sy, input int sx, input bit fl);
    next_y = Y_W'(ny); spr_y = Y_W'(sy); spr_x = X_W'(sx); flip_x = fl;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  // Reference: complete hit fetch of sprite row `row`, entered in cycle t+1.
  task automatic check_fetch(input string nm, input int row, input bit fl);
    logic [ADDR_W-1:0] ea;
    n_chk++;
    if ({busy, fetch_done} !== 2'b10) begin
      n_fail++; $display("FAIL %s check-cycle busy/done got %b want 10", nm, {busy, fetch_done});
    end
    for (int k = 0; k < SPR_W; k++) begin
      tick();
      ea = ADDR_W'(row * SPR_W + (fl ? SPR_W - 1 - k : k));
      n_chk++;
      if ({busy, fetch_done, rom_bus.rom_addr} !== {2'b10, ea}) begin
        n_fail++;
        $display("FAIL %s col %0d busy/done/addr got %b/%b/%0d want 1/0/%0d",
                 nm, k, busy, fetch_done, rom_bus.rom_addr, ea);
      end
    end
    tick();
    n_chk++;
    if ({busy, fetch_done} !== 2'b11) begin
      n_fail++; $display("FAIL %s drain busy/done got %b want 11", nm, {busy, fetch_done});
    end
    tick();
    n_chk++;
    if ({busy, fetch_done} !== 2'b00) begin
      n_fail++; $display("FAIL %s post-fetch busy/done got %b want 00", nm, {busy, fetch_done});
    end
  endtask

  // Reference: a miss completes in the check cycle and nothing follows.
  task automatic check_miss(input string nm);
    n_chk++;
    if ({busy, fetch_done} !== 2'b11) begin
      n_fail++; $display("FAIL %s miss busy/done got %b want 11", nm, {busy, fetch_done});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if ({busy, fetch_done} !== 2'b00) begin
        n_fail++; $display("FAIL %s after-miss busy/done got %b want 00", nm, {busy, fetch_done});
      end
    end
  endtask

  // Reference display model: a valid line shows mem[row*SPR_W + dx] (or the
  // mirrored column) for 0 <= dx < SPR_W; index 0 is see-through.
  task automatic sweep(input string nm, input bit ok, input int row, input int sx,
                       input bit fl, input int n, input bit rnd);
    int x, dx, v;
    bit inr;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        x = sx + int'($urandom_range(0, SPR_W + 40)) - 20;
        if (x < 0) x += 1 << X_W;
        if (x >= (1 << X_W)) x -= 1 << X_W;
      end else begin
        x = i;
      end
      draw_x = X_W'(x);
      tick();
      dx  = x - sx;
      inr = (dx >= 0) && (dx < SPR_W);
      v   = inr ? int'(mem[row * SPR_W + (fl ? SPR_W - 1 - dx : dx)]) : 0;
      n_chk++;
      if (ok) begin
        if ({pix_valid, pix_index} !== {(v != 0), DATA_W'(v)}) begin
          n_fail++;
          $display("FAIL %s x=%0d valid/index got %b/%0d want %b/%0d",
                   nm, x, pix_valid, pix_index, (v != 0), v);
        end
      end else if (pix_valid !== 1'b0) begin
        n_fail++; $display("FAIL %s x=%0d invalid line pix_valid got %b want 0", nm, x, pix_valid);
      end
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    n_chk++;
    if ({pix_valid, pix_index, rom_bus.rom_addr, busy, fetch_done} !== '0) begin
      n_fail++;
      $display("FAIL %s outputs valid/index/addr/busy/done got %b/%0d/%0d/%b/%b want all 0",
               nm, pix_valid, pix_index, rom_bus.rom_addr, busy, fetch_done);
    end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    tick(); tick();
    check_idle_outputs("reset");
    Reset_n = 1'b1;
    tick();
    check_idle_outputs("reset_release");
  endtask

  task automatic test_row0_and_display;
    start_line(100, 100, 200, 0);
    check_fetch("row0", 0, 0);
    start_line(182, 100, 0, 0);
    check_miss("row0_swap");
    sweep("row0_disp", 1, 0, 200, 0, 640, 0);
  endtask

  task automatic test_last_row;
    start_line(181, 100, 300, 0);
    check_fetch("row81", 81, 0);
    start_line(182, 100, 0, 0);
    check_miss("below");
    sweep("row81_disp", 1, 81, 300, 0, 200, 1);
  endtask

  task automatic test_miss;
    start_line(99, 100, 0, 0);
    check_miss("above");
    sweep("miss_line", 0, 0, 0, 0, 640, 0);
  endtask

  task automatic test_abort;
    start_line(100, 100, 50, 0);
    for (int k = 0; k < 30; k++) begin
      tick();
      n_chk++;
      if (rom_bus.rom_addr !== ADDR_W'(k)) begin
        n_fail++; $display("FAIL abort_pre col %0d addr got %0d want %0d", k, rom_bus.rom_addr, k);
      end
    end
    tick();
    start_line(105, 100, 400, 0);
    check_fetch("abort_restart", 5, 0);
    sweep("aborted_line", 0, 0, 50, 0, 640, 0);
    start_line(300, 100, 0, 0);
    check_miss("abort_swap");
    sweep("restart_disp", 1, 5, 400, 0, 200, 1);
  endtask

  task automatic test_reset_midfetch;
    start_line(120, 100, 10, 0);
    for (int k = 0; k < 10; k++) tick();
    Reset_n = 1'b0;
    #1;
    check_idle_outputs("reset_midfetch");
    tick();
    Reset_n = 1'b1;
    tick();
    start_line(0, 100, 0, 0);
    check_miss("post_reset_swap");
    sweep("post_reset_line", 0, 20, 10, 0, 120, 0);
  endtask

  task automatic test_random;
    int sy, row, sx;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
    for (int it = 0; it < 8; it++) begin
      sy  = int'($urandom_range(0, 900));
      row = int'($urandom_range(0, SPR_H - 1));
      sx  = int'($urandom_range(0, (1 << X_W) - 1));
      start_line(sy + row, sy, sx, 0);
      check_fetch("rand_fetch", row, 0);
      start_line(sy + SPR_H, sy, 0, 0);
      check_miss("rand_swap");
      sweep("rand_disp", 1, row, sx, 0, 150, 1);
    end
  endtask

`ifdef SPRITE_MIRROR_EN
  task automatic test_mirror;
    start_line(100, 100, 120, 1);
    check_fetch("mirror", 0, 1);
    start_line(182, 100, 0, 0);
    check_miss("mirror_swap");
    sweep("mirror_disp", 1, 0, 120, 1, 200, 1);
  endtask
`endif

  initial begin
    Reset_n = 1'b0; line_start = 1'b0; flip_x = 1'b0;
    next_y = '0; spr_y = '0; spr_x = '0; draw_x = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i & 15);
    test_reset();
    test_row0_and_display();
    test_last_row();
    test_miss();
    test_abort();
    test_reset_midfetch();
`ifdef SPRITE_MIRROR_EN
    test_mirror();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
